// File: rtl/burst_mem_if.sv
// burst_mem_if: rx/tx FIFO handshake bundle between the burst memory controller and its byte FIFOs
interface burst_mem_if #(parameter int FIFO_WIDTH = 8);
    logic                  rx_fifo_empty;
    logic [FIFO_WIDTH-1:0] din;
    logic                  tx_fifo_full;
    logic                  rx_fifo_rd_en;
    logic                  tx_fifo_wr_en;
    logic [FIFO_WIDTH-1:0] dout;
    logic [5:0]            state_leds;
    logic                  busy;
    modport master (
        input  rx_fifo_empty, din, tx_fifo_full,
        output rx_fifo_rd_en, tx_fifo_wr_en, dout, state_leds, busy
    );
    modport slave (
        output rx_fifo_empty, din, tx_fifo_full,
        input  rx_fifo_rd_en, tx_fifo_wr_en, dout, state_leds, busy
    );
endinterface

// File: rtl/burst_mem_controller.sv
// burst_mem_controller: byte-command front end (read/write/burst) to an internal synchronous-read memory.
// Define BURST_MEM_ACK_EN to acknowledge every completed write with a 0x4B byte.
module burst_mem_controller #(
    parameter int FIFO_WIDTH = 8,
    parameter int MEM_WIDTH  = 16,
    parameter int MEM_DEPTH  = 256,
    parameter int ADDR_BYTES = 1
) (
    input logic        clk,
    input logic        rst_n,
    burst_mem_if.master bus
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int NB = MEM_WIDTH / 8;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        GET_CMD  = 4'd1,
        GET_ADDR = 4'd2,
        GET_LEN  = 4'd3,
        GET_DATA = 4'd4,
        MEM_WR   = 4'd5,
        MEM_RD   = 4'd6,
        SEND     = 4'd7,
        SEND_ACK = 4'd8
    } state_t;

`ifdef BURST_MEM_ACK_EN
    localparam state_t WR_DONE = SEND_ACK;
`else
    localparam state_t WR_DONE = IDLE;
`endif

    state_t                state, nxt;
    logic                  pend;
    logic [1:0]            cmd;
    logic [AW-1:0]         addr;
    logic [FIFO_WIDTH-1:0] abuf;
    logic                  ab_cnt;
    logic [7:0]            len;
    logic [1:0]            bcnt;
    logic [MEM_WIDTH-1:0]  wbuf;
    logic [MEM_WIDTH-1:0]  rdata;
    logic [MEM_WIDTH-1:0]  mem [MEM_DEPTH];
    logic                  get_st, a_last, b_last, cmd_ok;

    assign get_st = state inside {GET_CMD, GET_ADDR, GET_LEN, GET_DATA};
    assign a_last = ab_cnt == 1'(ADDR_BYTES - 1);
    assign b_last = bcnt == 2'(NB - 1);
    assign cmd_ok = bus.din[7:2] == 6'b001100;

    // pend marks the cycle in which the byte popped last cycle is on din
    always_comb begin
        nxt = state;
        case (state)
            IDLE:     nxt = bus.rx_fifo_empty ? IDLE : GET_CMD;
            GET_CMD:  nxt = pend ? (cmd_ok ? GET_ADDR : IDLE) : GET_CMD;
            GET_ADDR: nxt = (pend && a_last) ? (cmd[1] ? GET_LEN : cmd[0] ? GET_DATA : MEM_RD) : GET_ADDR;
            GET_LEN:  nxt = pend ? (cmd[0] ? GET_DATA : MEM_RD) : GET_LEN;
            GET_DATA: nxt = (pend && b_last) ? MEM_WR : GET_DATA;
            MEM_WR:   nxt = (len == 8'd0) ? WR_DONE : GET_DATA;
            MEM_RD:   nxt = SEND;
            SEND:     nxt = (!bus.tx_fifo_full && b_last) ? ((len == 8'd0) ? IDLE : MEM_RD) : SEND;
            SEND_ACK: nxt = bus.tx_fifo_full ? SEND_ACK : IDLE;
            default:  nxt = IDLE;
        endcase
    end

    assign bus.rx_fifo_rd_en = get_st && !pend && !bus.rx_fifo_empty;
    assign bus.tx_fifo_wr_en = (state == SEND || state == SEND_ACK) && !bus.tx_fifo_full;
    assign bus.dout = (state == SEND) ? 8'(rdata >> {bcnt, 3'b000}) : (state == SEND_ACK) ? 8'h4B : 8'h00;
    assign bus.busy = state != IDLE;
    assign bus.state_leds = {cmd, state};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend   <= 1'b0;
            cmd    <= 2'd0;
            addr   <= '0;
            abuf   <= '0;
            ab_cnt <= 1'b0;
            len    <= 8'd0;
            bcnt   <= 2'd0;
            wbuf   <= '0;
        end else begin
            pend <= bus.rx_fifo_rd_en;
            if (state == GET_CMD && pend && cmd_ok) begin
                cmd    <= bus.din[1:0];
                ab_cnt <= 1'b0;
                len    <= 8'd0;
                bcnt   <= 2'd0;
            end
            if (state == GET_ADDR && pend) begin
                abuf   <= bus.din;
                addr   <= ab_cnt ? AW'({bus.din, abuf}) : AW'(bus.din);
                ab_cnt <= a_last ? 1'b0 : ab_cnt + 1'b1;
            end
            if (state == GET_LEN && pend)
                len <= bus.din;
            // bytes arrive LSB first, so each new byte enters at the top and shifts down
            if (state == GET_DATA && pend) begin
                wbuf <= (MEM_WIDTH'(bus.din) << (MEM_WIDTH - 8)) | (wbuf >> 8);
                bcnt <= b_last ? 2'd0 : bcnt + 2'd1;
            end
            if (state == MEM_WR) begin
                addr <= addr + 1'b1;
                if (len != 8'd0)
                    len <= len - 8'd1;
            end
            if (state == SEND && !bus.tx_fifo_full) begin
                bcnt <= b_last ? 2'd0 : bcnt + 2'd1;
                if (b_last) begin
                    addr <= addr + 1'b1;
                    if (len != 8'd0)
                        len <= len - 8'd1;
                end
            end
        end
    end

    // memory has no reset so its contents survive rst_n
    always_ff @(posedge clk) begin
        if (state == MEM_WR)
            mem[addr] <= wbuf;
        rdata <= mem[addr];
    end
endmodule

// File: tb/tb_burst_mem_controller.sv
// tb_burst_mem_controller: directed byte-command sequences against the default burst_mem_controller build
module tb_burst_mem_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    burst_mem_if #(.FIFO_WIDTH(8)) bus();
    burst_mem_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [7:0] rx_mem [1024];
    logic [7:0] tx_mem [1024];
    int rx_wr = 0, rx_rd = 0, tx_wr = 0, tx_rd = 0;
    int viol = 0, unstable = 0, stall_cnt = 0;
    int n_chk = 0, n_fail = 0;
    logic stall_prev = 1'b0;
    logic [7:0] dout_prev = 8'h00;
    logic tog_en = 1'b0, tog_full = 1'b0;
    int tog_cnt = 0;
    logic [7:0] ack_q [$];

    assign bus.rx_fifo_empty = rx_rd == rx_wr;
    assign bus.tx_fifo_full = tog_full;

    always @(posedge clk) begin
        if (bus.rx_fifo_rd_en) begin
            bus.din <= rx_mem[rx_rd];
            rx_rd <= rx_rd + 1;
        end
        if (bus.tx_fifo_wr_en) begin
            tx_mem[tx_wr] <= bus.dout;
            tx_wr <= tx_wr + 1;
        end
        if ((bus.rx_fifo_rd_en && bus.rx_fifo_empty) || (bus.tx_fifo_wr_en && bus.tx_fifo_full))
            viol <= viol + 1;
        if (stall_prev && bus.dout !== dout_prev)
            unstable <= unstable + 1;
        if (bus.tx_fifo_full && bus.state_leds[3:0] == 4'd7)
            stall_cnt <= stall_cnt + 1;
        stall_prev <= bus.tx_fifo_full && bus.state_leds[3:0] == 4'd7;
        dout_prev <= bus.dout;
        tog_cnt <= (tog_en && tog_cnt != 2) ? tog_cnt + 1 : 0;
        tog_full <= tog_en ? (tog_cnt == 2 ? ~tog_full : tog_full) : 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b [$]);
        @(negedge clk);
        foreach (b[i]) begin
            rx_mem[rx_wr] = b[i];
            rx_wr++;
        end
    endtask

    task automatic expect_tx(input string tag, input logic [7:0] exp [$]);
        bit done = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            done = bus.rx_fifo_empty && !bus.busy;
        end
        chk({tag, " idle"}, 32'(done), 32'd1);
        chk({tag, " count"}, tx_wr - tx_rd, exp.size());
        foreach (exp[i])
            chk($sformatf("%s byte%0d", tag, i), 32'(tx_mem[tx_rd + i]), 32'(exp[i]));
        tx_rd = tx_wr;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " busy"}, 32'(bus.busy), 32'd0);
        chk({tag, " leds"}, 32'(bus.state_leds), 32'd0);
        chk({tag, " dout"}, 32'(bus.dout), 32'd0);
        chk({tag, " rd_en"}, 32'(bus.rx_fifo_rd_en), 32'd0);
        chk({tag, " wr_en"}, 32'(bus.tx_fifo_wr_en), 32'd0);
    endtask

    initial begin
`ifdef BURST_MEM_ACK_EN
        ack_q.push_back(8'h4B);
`endif
        #1 chk_reset("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        push('{8'h31, 8'h05, 8'hCD, 8'hAB});
        expect_tx("wr5", ack_q);
        push('{8'h30, 8'h05});
        expect_tx("rd5", '{8'hCD, 8'hAB});

        push('{8'h33, 8'hFE, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66});
        expect_tx("bwr_wrap", ack_q);
        push('{8'h32, 8'hFE, 8'h02});
        expect_tx("brd_wrap", '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66});
        push('{8'h30, 8'h00});
        expect_tx("rd0_wrapped", '{8'h55, 8'h66});

        push('{8'h7A});
        expect_tx("bad_cmd", '{});
        push('{8'h30, 8'h05});
        expect_tx("rd5_after_bad", '{8'hCD, 8'hAB});
        push('{8'h32, 8'h05, 8'h00});
        expect_tx("brd_len0", '{8'hCD, 8'hAB});

        push('{8'h33, 8'h40, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08});
        expect_tx("bwr4", ack_q);
        tog_en = 1'b1;
        push('{8'h32, 8'h40, 8'h03});
        expect_tx("brd4_stall", '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08});
        tog_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("stalls_seen", 32'(stall_cnt > 0), 32'd1);
        chk("dout_stable", unstable, 0);

        push('{8'h32});
        repeat (8) @(negedge clk);
        chk("rx_stall leds", 32'(bus.state_leds), 32'h22);
        chk("rx_stall busy", 32'(bus.busy), 32'd1);
        chk("rx_stall rd_en", 32'(bus.rx_fifo_rd_en), 32'd0);
        push('{8'h40, 8'h00});
        expect_tx("rd40_late", '{8'h01, 8'h02});

        push('{8'h31, 8'h05, 8'hEE});
        for (int i = 0; i < 100 && rx_rd != rx_wr; i++)
            @(negedge clk);
        repeat (4) @(negedge clk);
        chk("partial leds", 32'(bus.state_leds), 32'h14);
        rst_n = 1'b0;
        #1 chk_reset("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        push('{8'h30, 8'h05});
        expect_tx("rd5_after_rst", '{8'hCD, 8'hAB});

        push('{8'h31, 8'h10, 8'h01, 8'h00});
        expect_tx("wr10_ack", ack_q);
        push('{8'h30, 8'h10});
        expect_tx("rd10", '{8'h01, 8'h00});

        chk("protocol", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/burst_mem_controller.md
BURST_MEM_CONTROLLER -- requirements
Module: burst_mem_controller

Interface
REQ-001 The block SHALL have parameter FIFO_WIDTH, default 8, giving the byte width of the rx/tx FIFO ports (fixed at 8).
REQ-002 The block SHALL have parameter MEM_WIDTH, default 16, giving the memory word width; legal values are 8, 16 and 32.
REQ-003 The block SHALL have parameter MEM_DEPTH, default 256, giving the number of words; legal values are powers of two from 16 to 65536.
REQ-004 The block SHALL have parameter ADDR_BYTES, default 1, giving the address bytes per command (1 or 2), LSB first.
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port rx_fifo_empty, input, 1 bit: high when the rx FIFO holds no byte.
REQ-008 Port din, input, FIFO_WIDTH bits: rx FIFO read data, valid the cycle after rx_fifo_rd_en.
REQ-009 Port tx_fifo_full, input, 1 bit: high when the tx FIFO cannot accept a byte.
REQ-010 Port rx_fifo_rd_en, output, 1 bit: pops one rx byte.
REQ-011 Port tx_fifo_wr_en, output, 1 bit: pushes dout into the tx FIFO.
REQ-012 Port dout, output, FIFO_WIDTH bits: byte presented to the tx FIFO.
REQ-013 Port state_leds, output, 6 bits: {2-bit command code, 4-bit FSM state}.
REQ-014 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 The block SHALL contain an internal memory of MEM_DEPTH x MEM_WIDTH with 1-cycle synchronous read.
REQ-016 rx_fifo_rd_en SHALL assert only when rx_fifo_empty is low, with at most one pop outstanding; the popped byte is captured from din the following cycle.
REQ-017 tx_fifo_wr_en SHALL assert only when tx_fifo_full is low; each assertion sends exactly one byte.
REQ-018 Commands SHALL be encoded as 0x30 read, 0x31 write, 0x32 burst read and 0x33 burst write, with command codes 0 to 3 on state_leds[5:4].
REQ-019 Any other command byte SHALL be discarded and the FSM SHALL return to IDLE without a memory access or tx output.
REQ-020 The FSM states SHALL be IDLE, GET_CMD, GET_ADDR, GET_LEN, GET_DATA, MEM_WR, MEM_RD, SEND and SEND_ACK.
REQ-021 The FSM flow SHALL be IDLE -> GET_CMD -> GET_ADDR (ADDR_BYTES bytes) -> GET_LEN (burst commands only) -> GET_DATA/MEM_WR (writes) or MEM_RD/SEND (reads) -> IDLE.
REQ-022 The address SHALL be taken from the low log2(MEM_DEPTH) bits of the received address bytes.
REQ-023 The burst length byte L SHALL transfer L+1 words (1 to 256); single read/write commands transfer 1 word.
REQ-024 Write data SHALL be assembled from MEM_WIDTH/8 bytes, LSB first; MEM_WR SHALL write the full word in one cycle, then continue to GET_DATA if words remain, else go to IDLE (or SEND_ACK).
REQ-025 MEM_RD SHALL issue the address and register the word after 1 cycle; SEND SHALL emit MEM_WIDTH/8 bytes LSB first, then MEM_RD for the next word or IDLE after the last.
REQ-026 The address SHALL increment by 1 per word and wrap from MEM_DEPTH-1 to 0.
REQ-027 In SEND, tx_fifo_full high SHALL stall the FSM with dout held stable, and no byte is lost or duplicated.
REQ-028 In the GET_* states, rx_fifo_empty high SHALL stall indefinitely with no timeout.

Reset
REQ-029 rst_n low SHALL immediately force IDLE and drive rx_fifo_rd_en=0, tx_fifo_wr_en=0, dout=0, busy=0 and state_leds=0.
REQ-030 Reset SHALL clear the command, address, length and byte counters but not the memory contents.
REQ-031 Reset asserted mid-command SHALL abandon the command; a partially assembled write word is not written.

Configuration
REQ-032 With macro BURST_MEM_ACK_EN defined, each write or burst write SHALL, after its last MEM_WR, enter SEND_ACK and send one byte 0x4B, stalling while tx_fifo_full is high.
REQ-033 Without BURST_MEM_ACK_EN, SEND_ACK SHALL not be reachable and write commands SHALL produce no tx output.

Verification (defaults: MEM_WIDTH=16, MEM_DEPTH=256, ADDR_BYTES=1)
REQ-034 rx 31 05 CD AB, then 30 05 -> tx AB? no: tx CD AB (word 0xABCD at address 5).
REQ-035 rx 33 FE 02 11 22 33 44 55 66, then 32 FE 02 -> tx 11 22 33 44 55 66 (addresses FE, FF, 00, wrap).
REQ-036 rx 7A, then 30 05 -> no tx for 0x7A; tx CD AB for the read.
REQ-037 Burst read of 4 words with tx_fifo_full toggling every 3 cycles -> exactly 8 bytes in order; dout stable while stalled.
REQ-038 rst_n pulsed low after 31 05 CD -> IDLE within the pulse; subsequent 30 05 -> tx CD AB (prior contents kept).
REQ-039 With BURST_MEM_ACK_EN defined, rx 31 10 01 00 -> tx 4B; without it -> no tx.
